// File: rtl/adc_init_sequencer.sv
// Power-up configuration sequencer for the external ADC: waits a power-up delay,
// then writes four 16-bit config words over write-only SPI (mode 0, MSB first).
// Ports: i_clock/i_reset (sync, active-high), i_reinit (resend request, honoured
// only in DONE); o_spi_cs_n/o_spi_sclk/o_spi_mosi SPI link; o_busy, o_adc_init_done status.
module adc_init_sequencer #(
  parameter int          POWERUP_TICKS = 1000,
  parameter int          CLK_DIV       = 4,
  parameter int          CS_GAP        = 8,
  parameter logic [15:0] CFG_WORD0     = 16'h8000,
  parameter logic [15:0] CFG_WORD1     = 16'h0103,
  parameter logic [15:0] CFG_WORD2     = 16'h0210,
  parameter logic [15:0] CFG_WORD3     = 16'h0300
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_reinit,
  output logic o_spi_cs_n,
  output logic o_spi_sclk,
  output logic o_spi_mosi,
  output logic o_busy,
  output logic o_adc_init_done
);

  localparam int MAX_A     = (POWERUP_TICKS > CLK_DIV) ? POWERUP_TICKS : CLK_DIV;
  localparam int MAX_TICKS = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
  localparam int TICK_W    = $clog2(MAX_TICKS + 1);

  localparam logic [TICK_W-1:0] POWERUP_LAST = TICK_W'(POWERUP_TICKS);
  localparam logic [TICK_W-1:0] HALF_LAST    = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] GAP_LAST     = TICK_W'(CS_GAP - 1);
  localparam logic [TICK_W-1:0] TICK_ONE     = TICK_W'(1);

  localparam logic [1:0] ST_POWERUP = 2'd0;
  localparam logic [1:0] ST_FRAME   = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state;
  logic [TICK_W-1:0] tick;
  logic [3:0]        bit_cnt;
  logic [1:0]        word_idx;
  logic [15:0]       cur_word;
  logic [15:0]       next_word;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_WORD0;
      2'd1:    return CFG_WORD1;
      2'd2:    return CFG_WORD2;
      default: return CFG_WORD3;
    endcase
  endfunction

  assign cur_word  = cfg_word(word_idx);
  assign next_word = cfg_word(word_idx + 2'd1);

  // POWERUP counts from 0 on the first released edge, so comparing against
  // POWERUP_TICKS (not -1) lands the cs_n fall exactly on cycle POWERUP_TICKS.
  // In FRAME and GAP the tick is cleared on the entry edge, so the "-1"
  // compares give exactly CLK_DIV / CS_GAP cycles per phase.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= ST_POWERUP;
      tick            <= '0;
      bit_cnt         <= '0;
      word_idx        <= '0;
      o_spi_cs_n      <= 1'b1;
      o_spi_sclk      <= 1'b0;
      o_spi_mosi      <= 1'b0;
      o_busy          <= 1'b0;
      o_adc_init_done <= 1'b0;
    end else begin
      case (state)
        ST_POWERUP: begin
          o_busy <= 1'b1;
          if (tick == POWERUP_LAST) begin
            state      <= ST_FRAME;
            tick       <= '0;
            bit_cnt    <= 4'd15;
            o_spi_cs_n <= 1'b0;
            o_spi_mosi <= cur_word[15];
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

        ST_FRAME: begin
          if (tick == HALF_LAST) begin
            tick <= '0;
            if (!o_spi_sclk) begin
              o_spi_sclk <= 1'b1;
            end else begin
              // Falling edge: either shift out the next bit or close the frame.
              o_spi_sclk <= 1'b0;
              if (bit_cnt == 4'd0) begin
                state      <= ST_GAP;
                o_spi_cs_n <= 1'b1;
                o_spi_mosi <= 1'b0;
              end else begin
                bit_cnt    <= bit_cnt - 4'd1;
                o_spi_mosi <= cur_word[bit_cnt - 4'd1];
              end
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

        ST_GAP: begin
          if (tick == GAP_LAST) begin
            tick <= '0;
            if (word_idx == 2'd3) begin
              state           <= ST_DONE;
              o_busy          <= 1'b0;
              o_adc_init_done <= 1'b1;
            end else begin
              state      <= ST_FRAME;
              word_idx   <= word_idx + 2'd1;
              bit_cnt    <= 4'd15;
              o_spi_cs_n <= 1'b0;
              o_spi_mosi <= next_word[15];
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

        ST_DONE: begin
          // Reinit skips the power-up delay and starts frame 0 on this edge.
          if (i_reinit) begin
            state           <= ST_FRAME;
            tick            <= '0;
            word_idx        <= 2'd0;
            bit_cnt         <= 4'd15;
            o_spi_cs_n      <= 1'b0;
            o_spi_mosi      <= CFG_WORD0[15];
            o_busy          <= 1'b1;
            o_adc_init_done <= 1'b0;
          end
        end

        default: begin
          state <= ST_POWERUP;
          tick  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_init_sequencer.sv
// Testbench for adc_init_sequencer: two instances (bench timing and minimum
// divider), an SPI monitor decoding frames against a queue of expected words,
// and scenario tasks checking timing of cs_n, busy and done.
module tb_adc_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst    = 2'b11;
  logic [1:0] reinit = 2'b00;
  logic [1:0] cs_n, sclk, mosi, busy, done;

  int checks = 0;
  int errors = 0;

  int          div [2] = '{2, 1};
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // Monitor state
  logic [1:0]  p_cs   = 2'b11;
  logic [1:0]  p_sclk = 2'b00;
  logic [1:0]  p_mosi = 2'b00;
  logic [1:0]  abort  = 2'b00;
  int          bits [2];
  int          low [2];
  int          frames_done [2];
  logic [15:0] sh [2];

  // Sequence measurement results
  int   m_cs_cyc, m_done_cyc, m_busy_bad;
  logic m_done_busy, m_c0_cs, m_c0_mosi, m_c0_busy, m_c0_done;
  bit   m_pulsed;

  adc_init_sequencer #(
    .POWERUP_TICKS(10), .CLK_DIV(2), .CS_GAP(3)
  ) dut (
    .i_clock(clk), .i_reset(rst[0]), .i_reinit(reinit[0]),
    .o_spi_cs_n(cs_n[0]), .o_spi_sclk(sclk[0]), .o_spi_mosi(mosi[0]),
    .o_busy(busy[0]), .o_adc_init_done(done[0])
  );

  adc_init_sequencer #(
    .POWERUP_TICKS(1), .CLK_DIV(1), .CS_GAP(1),
    .CFG_WORD0(16'hFFFF), .CFG_WORD1(16'h0000)
  ) dut_min (
    .i_clock(clk), .i_reset(rst[1]), .i_reinit(reinit[1]),
    .o_spi_cs_n(cs_n[1]), .o_spi_sclk(sclk[1]), .o_spi_mosi(mosi[1]),
    .o_busy(busy[1]), .o_adc_init_done(done[1])
  );

  // SPI monitor: samples on the falling clock edge, decodes mosi on sclk rises
  initial begin
    logic [15:0] exp_w;
    bit          have;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (cs_n[i] === 1'b1 && sclk[i] !== 1'b0) begin
          errors++;
          $display("FAIL sclk_idle dut%0d: sclk=%b while cs_n high, required 0", i, sclk[i]);
        end
        if (cs_n[i] === 1'b0 && p_cs[i] === 1'b0) begin
          checks++;
          if (mosi[i] !== p_mosi[i] && !(p_sclk[i] && !sclk[i])) begin
            errors++;
            $display("FAIL mosi_stable dut%0d: mosi changed to %b without sclk fall", i, mosi[i]);
          end
        end
        if (cs_n[i] === 1'b0) begin
          if (p_cs[i] === 1'b1) begin
            bits[i] = 0;
            low[i]  = 0;
          end
          low[i]++;
          if (sclk[i] === 1'b1 && p_sclk[i] === 1'b0) begin
            sh[i] = {sh[i][14:0], mosi[i]};
            bits[i]++;
          end
        end
        if (cs_n[i] === 1'b1 && p_cs[i] === 1'b0) begin
          if (abort[i]) begin
            abort[i] = 1'b0;
          end else begin
            have = 1'b0;
            if (i == 0 && q0.size() > 0) begin exp_w = q0.pop_front(); have = 1'b1; end
            else if (i == 1 && q1.size() > 0) begin exp_w = q1.pop_front(); have = 1'b1; end
            checks++;
            if (!have) begin
              errors++;
              $display("FAIL frame_unexpected dut%0d: got word %h, none expected", i, sh[i]);
            end else if (sh[i] !== exp_w) begin
              errors++;
              $display("FAIL frame_word dut%0d: got %h, required %h", i, sh[i], exp_w);
            end
            checks++;
            if (bits[i] != 16) begin
              errors++;
              $display("FAIL frame_sclk_rises dut%0d: got %0d, required 16", i, bits[i]);
            end
            checks++;
            if (low[i] != 32 * div[i]) begin
              errors++;
              $display("FAIL frame_cs_low dut%0d: got %0d, required %0d", i, low[i], 32 * div[i]);
            end
            frames_done[i]++;
          end
        end
        p_cs[i]   = cs_n[i];
        p_sclk[i] = sclk[i];
        p_mosi[i] = mosi[i];
      end
    end
  end

  // Counts edges from the next rising edge (cycle 0) until done rises.
  // reinit is held for 'hold' edges; optionally pulsed once during frame 1.
  task automatic measure_seq(input int idx, input int hold, input bit pulse_f1);
    int rel_k;
    rel_k       = hold - 1;
    m_cs_cyc    = -1;
    m_done_cyc  = -1;
    m_busy_bad  = 0;
    m_pulsed    = 1'b0;
    m_done_busy = 1'bx;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        m_c0_cs   = cs_n[idx];
        m_c0_mosi = mosi[idx];
        m_c0_busy = busy[idx];
        m_c0_done = done[idx];
      end
      if (k >= rel_k) reinit[idx] = 1'b0;
      if (m_cs_cyc < 0 && cs_n[idx] === 1'b0) m_cs_cyc = k;
      if (done[idx] === 1'b1) begin
        m_done_cyc  = k;
        m_done_busy = busy[idx];
        break;
      end
      if (busy[idx] !== 1'b1) m_busy_bad++;
      if (pulse_f1 && !m_pulsed && frames_done[idx] == 1 && cs_n[idx] === 1'b0) begin
        reinit[idx] = 1'b1;
        m_pulsed    = 1'b1;
        rel_k       = k + 1;
      end
    end
    reinit[idx] = 1'b0;
  endtask

  task automatic push_default_words();
    q0.delete();
    q0.push_back(16'h8000);
    q0.push_back(16'h0103);
    q0.push_back(16'h0210);
    q0.push_back(16'h0300);
    frames_done[0] = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (cs_n[i] !== 1'b1) begin errors++; $display("FAIL reset_cs_n dut%0d: got %b, required 1", i, cs_n[i]); end
      checks++; if (sclk[i] !== 1'b0) begin errors++; $display("FAIL reset_sclk dut%0d: got %b, required 0", i, sclk[i]); end
      checks++; if (mosi[i] !== 1'b0) begin errors++; $display("FAIL reset_mosi dut%0d: got %b, required 0", i, mosi[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b, required 0", i, busy[i]); end
      checks++; if (done[i] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b, required 0", i, done[i]); end
    end
  endtask

  task automatic test_startup();
    push_default_words();
    rst[0] = 1'b0;
    measure_seq(0, 0, 1'b0);
    checks++; if (m_c0_busy !== 1'b1) begin errors++; $display("FAIL startup_busy_c0: got %b, required 1", m_c0_busy); end
    checks++; if (m_cs_cyc != 10) begin errors++; $display("FAIL startup_cs_fall: got %0d, required 10", m_cs_cyc); end
    checks++; if (m_done_cyc != 278) begin errors++; $display("FAIL startup_done: got %0d, required 278", m_done_cyc); end
    checks++; if (m_busy_bad != 0) begin errors++; $display("FAIL startup_busy_gaps: got %0d low cycles, required 0", m_busy_bad); end
    checks++; if (m_done_busy !== 1'b0) begin errors++; $display("FAIL startup_busy_at_done: got %b, required 0", m_done_busy); end
    checks++; if (frames_done[0] != 4 || q0.size() != 0) begin errors++; $display("FAIL startup_frames: got %0d frames, %0d pending, required 4 and 0", frames_done[0], q0.size()); end
  endtask

  task automatic test_reinit();
    push_default_words();
    reinit[0] = 1'b1;
    measure_seq(0, 1, 1'b1);
    checks++; if (m_c0_done !== 1'b0) begin errors++; $display("FAIL reinit_done_c0: got %b, required 0", m_c0_done); end
    checks++; if (m_c0_cs !== 1'b0) begin errors++; $display("FAIL reinit_cs_c0: got %b, required 0", m_c0_cs); end
    checks++; if (m_c0_mosi !== 1'b1) begin errors++; $display("FAIL reinit_mosi_c0: got %b, required 1", m_c0_mosi); end
    checks++; if (m_c0_busy !== 1'b1) begin errors++; $display("FAIL reinit_busy_c0: got %b, required 1", m_c0_busy); end
    checks++; if (!m_pulsed) begin errors++; $display("FAIL reinit_frame1_pulse: got no pulse, required one during frame 1"); end
    checks++; if (m_done_cyc != 268) begin errors++; $display("FAIL reinit_done: got %0d, required 268", m_done_cyc); end
    checks++; if (frames_done[0] != 4 || q0.size() != 0) begin errors++; $display("FAIL reinit_frames: got %0d frames, %0d pending, required 4 and 0", frames_done[0], q0.size()); end
  endtask

  task automatic test_reinit_held();
    push_default_words();
    reinit[0] = 1'b1;
    measure_seq(0, 4, 1'b0);
    checks++; if (m_done_cyc != 268) begin errors++; $display("FAIL held_done: got %0d, required 268", m_done_cyc); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done[0] !== 1'b1 || cs_n[0] !== 1'b1) begin errors++; $display("FAIL held_single_seq: got done=%b cs_n=%b, required 1 1", done[0], cs_n[0]); end
    checks++; if (frames_done[0] != 4 || q0.size() != 0) begin errors++; $display("FAIL held_frames: got %0d frames, %0d pending, required 4 and 0", frames_done[0], q0.size()); end
  endtask

  task automatic test_reset_midframe();
    bit found;
    push_default_words();
    reinit[0] = 1'b1;
    @(posedge clk);
    #1;
    reinit[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (frames_done[0] == 2 && bits[0] == 7 && cs_n[0] === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midframe_reach: got no 7th rise of frame 2, required one"); end
    abort[0] = 1'b1;
    rst[0]   = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (cs_n[0] !== 1'b1) begin errors++; $display("FAIL midframe_cs_n: got %b, required 1", cs_n[0]); end
    checks++; if (sclk[0] !== 1'b0 || mosi[0] !== 1'b0) begin errors++; $display("FAIL midframe_spi: got sclk=%b mosi=%b, required 0 0", sclk[0], mosi[0]); end
    checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL midframe_status: got busy=%b done=%b, required 0 0", busy[0], done[0]); end
    push_default_words();
    rst[0] = 1'b0;
    measure_seq(0, 0, 1'b0);
    checks++; if (m_cs_cyc != 10) begin errors++; $display("FAIL midframe_cs_fall: got %0d, required 10", m_cs_cyc); end
    checks++; if (m_done_cyc != 278) begin errors++; $display("FAIL midframe_done: got %0d, required 278", m_done_cyc); end
    checks++; if (frames_done[0] != 4 || q0.size() != 0) begin errors++; $display("FAIL midframe_frames: got %0d frames, %0d pending, required 4 and 0", frames_done[0], q0.size()); end
  endtask

  task automatic test_reset_with_reinit();
    rst[0]    = 1'b1;
    reinit[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (cs_n[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL rst_reinit: got cs_n=%b done=%b busy=%b, required 1 0 0", cs_n[0], done[0], busy[0]); end
    reinit[0] = 1'b0;
    push_default_words();
    rst[0] = 1'b0;
    measure_seq(0, 0, 1'b0);
    checks++; if (m_cs_cyc != 10) begin errors++; $display("FAIL rst_reinit_cs_fall: got %0d, required 10", m_cs_cyc); end
    checks++; if (m_done_cyc != 278) begin errors++; $display("FAIL rst_reinit_done: got %0d, required 278", m_done_cyc); end
  endtask

  task automatic test_min_divider();
    q1.delete();
    q1.push_back(16'hFFFF);
    q1.push_back(16'h0000);
    q1.push_back(16'h0210);
    q1.push_back(16'h0300);
    frames_done[1] = 0;
    rst[1] = 1'b0;
    measure_seq(1, 0, 1'b0);
    checks++; if (m_cs_cyc != 1) begin errors++; $display("FAIL min_cs_fall: got %0d, required 1", m_cs_cyc); end
    checks++; if (m_done_cyc != 133) begin errors++; $display("FAIL min_done: got %0d, required 133", m_done_cyc); end
    checks++; if (m_busy_bad != 0) begin errors++; $display("FAIL min_busy_gaps: got %0d low cycles, required 0", m_busy_bad); end
    checks++; if (frames_done[1] != 4 || q1.size() != 0) begin errors++; $display("FAIL min_frames: got %0d frames, %0d pending, required 4 and 0", frames_done[1], q1.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      bits[i]        = 0;
      low[i]         = 0;
      frames_done[i] = 0;
      sh[i]          = '0;
    end
    test_reset();
    test_startup();
    test_reinit();
    test_reinit_held();
    test_reset_midframe();
    test_reset_with_reinit();
    test_min_divider();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_init_sequencer.md
# adc_init_sequencer

Power-up configuration sequencer for the external ADC. After reset it waits a fixed power-up delay, then writes four 16-bit configuration words to the ADC over a write-only SPI link (mode 0, MSB first). When the last word is written it raises `o_adc_init_done`, which feeds the RGB status LED unit and gates the acquisition path downstream.

## Interface
- `POWERUP_TICKS`, 1000: `i_clock` cycles to wait after reset release before the first frame (≥1).
- `CLK_DIV`, 4: `i_clock` cycles per SCLK half-period (≥1).
- `CS_GAP`, 8: `i_clock` cycles that CS_n stays high between frames and after the last frame (≥1).
- `CFG_WORD0`, 16'h8000: first word (soft reset).
- `CFG_WORD1`, 16'h0103: second word.
- `CFG_WORD2`, 16'h0210: third word.
- `CFG_WORD3`, 16'h0300: fourth word.
- `i_clock` input 1: system clock. All logic is on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_reinit` input 1: single-cycle request to re-send all four words. Honoured only in DONE.
- `o_spi_cs_n` output 1: ADC chip select, active low.
- `o_spi_sclk` output 1: SPI clock, idles low.
- `o_spi_mosi` output 1: SPI data to the ADC.
- `o_busy` output 1: high while the sequence is in progress.
- `o_adc_init_done` output 1: high once all four words are written. Held high until reset or reinit.

## Operation
- All outputs are registered. While `i_reset`=1: cs_n=1, sclk=0, mosi=0, busy=0, done=0, word index=0, all counters=0.
- States:
  - POWERUP → FRAME: after POWERUP_TICKS cycles.
  - FRAME → GAP: after 16 bits.
  - GAP → FRAME: after CS_GAP cycles if the word index < 3 (index increments).
  - GAP → DONE: after CS_GAP cycles if the word index = 3.
  - DONE → FRAME: on `i_reinit`; word index resets to 0 and POWERUP is skipped.
- FRAME:
  - On entry, cs_n=0 and mosi=bit15 of the current word on the same edge; sclk stays 0.
  - Each bit lasts 2·CLK_DIV cycles: sclk low for CLK_DIV, then high for CLK_DIV.
  - mosi changes only on the edge where sclk falls, or on frame entry. It is stable around each sclk rise.
  - After bit 0's high phase, sclk falls and cs_n rises on the same edge. mosi returns to 0 on that edge.
  - cs_n is low for exactly 32·CLK_DIV cycles per frame, with exactly 16 sclk rising edges.
- GAP: cs_n=1, sclk=0, mosi=0 for CS_GAP cycles.
- DONE: done=1, busy=0; SPI outputs are idle (cs_n=1, sclk=0, mosi=0).
- `o_busy` is 1 in POWERUP, FRAME and GAP.
- The word index is 2 bits and selects CFG_WORD0..3. The bit counter is 4 bits and counts 15 down to 0. The tick counter is wide enough for max(POWERUP_TICKS, CLK_DIV, CS_GAP).

## Timing
- Cycle 0 is the first rising edge with `i_reset`=0.
  - Cycle 0: busy=1, state POWERUP.
  - Cycle POWERUP_TICKS: cs_n falls for frame 0.
- Each frame plus its gap is 32·CLK_DIV + CS_GAP cycles.
- done rises at cycle POWERUP_TICKS + 4·(32·CLK_DIV + CS_GAP). busy falls on the same edge.
  - With defaults: 1000 + 4·136 = 1544.
- Reinit: on the edge where `i_reinit`=1 in DONE, done goes to 0, busy to 1, cs_n to 0, and mosi to CFG_WORD0[15], all together. done returns 4·(32·CLK_DIV + CS_GAP) cycles later.
- `i_reinit` outside DONE is ignored, with no latching. `i_reinit` held high for several cycles in DONE starts a single sequence.
- `i_reset` mid-frame or mid-gap:
  - Outputs take their reset values on that edge, so cs_n goes high even mid-bit.
  - After release, the full POWERUP delay is repeated.
  - A simultaneous reset and reinit is treated as reset.
- No sclk glitches: sclk only toggles while cs_n=0.

## Test plan
1. Bench parameters POWERUP_TICKS=10, CLK_DIV=2, CS_GAP=3; release reset → first cs_n fall at cycle 10; done rises at cycle 10 + 4·67 = 278; busy=1 over cycles 0–277.
2. Default words, SPI monitor sampling mosi on sclk rise → four frames decoded as 16'h8000, 16'h0103, 16'h0210, 16'h0300, in order, each with exactly 16 sclk rises and cs_n low for 64 cycles (CLK_DIV=2).
3. Hold reset, then release, and check all outputs during reset → cs_n=1, sclk=0, mosi=0, busy=0, done=0.
4. Assert reset at the 7th sclk rise of frame 2, hold 1 cycle, release → cs_n=1 on the reset edge; the sequence restarts with POWERUP and frame 0 = 16'h8000; done at 278 cycles after the second release.
5. In DONE, pulse `i_reinit` for 1 cycle → same edge done=0, cs_n=0, mosi=1; four frames are re-sent; done returns 268 cycles later. A `i_reinit` pulse during frame 1 leaves the done time unchanged.
6. CLK_DIV=1, CS_GAP=1, POWERUP_TICKS=1 with CFG_WORD0=16'hFFFF and CFG_WORD1=16'h0000 → correct decode at the minimum divider; done at cycle 1 + 4·33 = 133.
